// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifetch_ctrl_pkg;

  localparam int unsigned IFETCH_ADDR_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_FILL = ST_FILL,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Instruction class field encodings used by decode.
  localparam logic [1:0] ICLASS_R  = 2'b00;
  localparam logic [1:0] ICLASS_I  = 2'b01;
  localparam logic [1:0] ICLASS_LS = 2'b10;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: streams words from a combinational memory to decode.
// Define IFETCH_BRANCH_EN to enable br_valid/br_target redirects; otherwise they are ignored.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = IFETCH_ADDR_W,
  parameter int unsigned PROG_LEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_code,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   fetch_cnt
);

  localparam int unsigned     PC_W   = ADDR_W + 1;
  localparam logic [PC_W-1:0] PC_END = PC_W'(PROG_LEN);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              accept_c;
  logic              load_c;

`ifndef IFETCH_BRANCH_EN
  logic unused_br;
  assign unused_br = ^{br_valid, br_target};
`endif

  // Next-state, pc and output-register computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_cnt_d  = fetch_cnt_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    load_c       = 1'b0;
    accept_c     = inst_valid_q & inst_ready;

    if (accept_c && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + PC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FILL;
      end
      S_FILL: begin
        if (halt_req) begin
          state_d = S_IDLE;
        end else begin
          load_c  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // An unaccepted held word is dropped and refetched on resume.
        if (halt_req) begin
          inst_valid_d = 1'b0;
          state_d      = S_IDLE;
          if (!accept_c) pc_d = {1'b0, inst_pc_q};
        end
`ifdef IFETCH_BRANCH_EN
        else if (br_valid) begin
          pc_d         = {1'b0, br_target};
          inst_valid_d = 1'b0;
          state_d      = S_FILL;
        end
`endif
        else if (accept_c) begin
          if (pc_q >= PC_END) begin
            inst_valid_d = 1'b0;
            state_d      = S_DONE;
          end else begin
            load_c = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          pc_d        = '0;
          fetch_cnt_d = '0;
          state_d     = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_c) begin
      inst_d       = mem_code;
      inst_pc_d    = pc_q[ADDR_W-1:0];
      pc_d         = pc_q + PC_W'(1);
      inst_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      fetch_cnt_q  <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_cnt_q  <= fetch_cnt_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign mem_addr   = pc_q[ADDR_W-1:0];
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign busy       = (state_q == S_FILL) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: transaction-level model plus directed scenarios.
module tb_ifetch_ctrl;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned PROG_LEN = 8;
`ifdef IFETCH_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, start, halt_req, inst_ready, br_valid;
  logic [ADDR_W-1:0] br_target, mem_addr, inst_pc;
  logic [31:0]       mem_code, inst;
  logic              inst_valid, busy, done;
  logic [ADDR_W:0]   fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 filling, 2 word held, 3 done.
  int ph      = 0;
  int exp_pc  = 0;
  int cnt     = 0;
  bit armed   = 1'b0;
  bit acc;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return {8'hA5, 2'b00, a, 8'h3C, 2'b00, ~a};
  endfunction

  assign mem_code = word_of(mem_addr);

  ifetch_ctrl #(.ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt_req   (halt_req),
    .mem_addr   (mem_addr),
    .mem_code   (mem_code),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .busy       (busy),
    .done       (done),
    .fetch_cnt  (fetch_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // Compare against the model, then predict the effect of the coming edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_busy", 32'(busy), 32'(ph == 1 || ph == 2));
      chk("m_done", 32'(done), 32'(ph == 3));
      chk("m_valid", 32'(inst_valid), 32'(ph == 2));
      chk("m_cnt", 32'(fetch_cnt), 32'(cnt));
      if (ph == 0 || ph == 1) chk("m_addr", 32'(mem_addr), 32'(ADDR_W'(exp_pc)));
      if (ph == 2) begin
        chk("m_inst_pc", 32'(inst_pc), 32'(ADDR_W'(exp_pc)));
        chk("m_inst", inst, word_of(ADDR_W'(exp_pc)));
        chk("m_addr_run", 32'(mem_addr), 32'(ADDR_W'(exp_pc + 1)));
      end
    end
    if (!rst_n) begin
      ph = 0; exp_pc = 0; cnt = 0; armed = 1'b1;
    end else begin
      case (ph)
        0: if (start) ph = 1;
        1: ph = halt_req ? 0 : 2;
        2: begin
          acc = inst_ready;
          if (acc && cnt < 127) cnt = cnt + 1;
          if (halt_req) begin
            if (acc) exp_pc = exp_pc + 1;
            ph = 0;
          end else if (BR_EN && br_valid) begin
            exp_pc = int'(br_target);
            ph = 1;
          end else if (acc) begin
            exp_pc = exp_pc + 1;
            if (exp_pc >= PROG_LEN) ph = 3;
          end
        end
        default: if (start) begin ph = 1; exp_pc = 0; cnt = 0; end
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input int pc, input string nm);
    bit found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (inst_valid && inst_pc == ADDR_W'(pc)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string nm);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; inst_ready = 1'b0;
    br_valid = 1'b0; br_target = '0;

    // Reset state
    cyc(); cyc();
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_cnt", 32'(fetch_cnt), 32'd0);
    chk("rst_inst", inst, 32'd0);

    // Full throughput run
    inst_ready = 1'b1;
    pulse_start();
    chk("lat1_valid", 32'(inst_valid), 32'd0);
    chk("lat1_busy", 32'(busy), 32'd1);
    cyc();
    chk("lat2_valid", 32'(inst_valid), 32'd1);
    chk("lat2_pc", 32'(inst_pc), 32'd0);
    chk("lat2_inst", inst, 32'hA500_3C3F);
    wait_done("full_timeout");
    chk("full_cnt", 32'(fetch_cnt), 32'd8);
    chk("full_done", 32'(done), 32'd1);
    chk("full_busy", 32'(busy), 32'd0);

    // Backpressure with inst_ready toggling
    inst_ready = 1'b0;
    pulse_start();
    chk("bp_cnt_clr", 32'(fetch_cnt), 32'd0);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        inst_ready = 1'(i % 2);
        cyc();
        if (done) begin found = 1'b1; break; end
      end
      if (!found) chk("bp_timeout", 32'd0, 32'd1);
    end
    chk("bp_cnt", 32'(fetch_cnt), 32'd8);

    // Branch while word 2 is held unaccepted
    inst_ready = 1'b1;
    pulse_start();
    wait_pc(2, "br_wait");
    inst_ready = 1'b0; br_valid = 1'b1; br_target = 6'd5;
    cyc();
    br_valid = 1'b0;
    chk("br_cnt", 32'(fetch_cnt), 32'd2);
`ifdef IFETCH_BRANCH_EN
    chk("br_bubble", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    cyc();
    chk("br_pc", 32'(inst_pc), 32'd5);
    wait_done("br_done_timeout");
    chk("br_final_cnt", 32'(fetch_cnt), 32'd5);

    // Branch beyond the program end: word still delivered, then done
    pulse_start();
    wait_pc(1, "brx_wait");
    br_valid = 1'b1; br_target = 6'd10;
    cyc();
    br_valid = 1'b0;
    chk("brx_bubble", 32'(inst_valid), 32'd0);
    chk("brx_addr", 32'(mem_addr), 32'd10);
    cyc();
    chk("brx_pc", 32'(inst_pc), 32'd10);
    cyc();
    chk("brx_done", 32'(done), 32'd1);
    chk("brx_cnt", 32'(fetch_cnt), 32'd3);
`else
    chk("nobr_pc2", 32'(inst_pc), 32'd2);
    chk("nobr_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    cyc();
    chk("nobr_pc3", 32'(inst_pc), 32'd3);
    cyc();
    chk("nobr_pc4", 32'(inst_pc), 32'd4);
    wait_done("nobr_done_timeout");
    chk("nobr_final_cnt", 32'(fetch_cnt), 32'd8);
`endif

    // Halt with word 3 held, then resume
    inst_ready = 1'b1;
    pulse_start();
    wait_pc(3, "halt_wait");
    inst_ready = 1'b0; halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_valid", 32'(inst_valid), 32'd0);
    chk("halt_cnt", 32'(fetch_cnt), 32'd3);
    pulse_start();
    cyc();
    chk("resume_pc", 32'(inst_pc), 32'd3);
    chk("resume_cnt", 32'(fetch_cnt), 32'd3);
    inst_ready = 1'b1;
    wait_done("halt_done_timeout");
    chk("halt_final_cnt", 32'(fetch_cnt), 32'd8);

    // Halt and branch together: halt wins
    pulse_start();
    wait_pc(2, "hb_wait");
    inst_ready = 1'b0; halt_req = 1'b1; br_valid = 1'b1; br_target = 6'd6;
    cyc();
    halt_req = 1'b0; br_valid = 1'b0;
    chk("hb_busy", 32'(busy), 32'd0);
    chk("hb_valid", 32'(inst_valid), 32'd0);
    pulse_start();
    cyc();
    chk("hb_resume_pc", 32'(inst_pc), 32'd2);

    // Reset mid-run at word 4
    inst_ready = 1'b1;
    wait_pc(4, "rr_wait");
    inst_ready = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_valid", 32'(inst_valid), 32'd0);
    chk("rr_addr", 32'(mem_addr), 32'd0);
    chk("rr_cnt", 32'(fetch_cnt), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 6, instruction-memory address width (64 words).
REQ-002 SHALL have parameter: PROG_LEN, 64, number of words fetched before DONE (1..2^ADDR_W).
REQ-003 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port: start  in  1  begin or resume fetching (level-sampled in IDLE/DONE).
REQ-006 SHALL have port: halt_req  in  1  stop fetching, keep PC.
REQ-007 SHALL have port: mem_addr  out  ADDR_W  word address to the combinational instruction memory.
REQ-008 SHALL have port: mem_code  in  32  instruction word returned for mem_addr in the same cycle.
REQ-009 SHALL have port: inst  out  32  registered instruction to decode.
REQ-010 SHALL have port: inst_pc  out  ADDR_W  address inst was fetched from.
REQ-011 SHALL have port: inst_valid  out  1 / inst_ready  in  1  valid/ready handshake to decode.
REQ-012 SHALL have port: br_valid  in  1 / br_target  in  ADDR_W  fetch redirect.
REQ-013 SHALL have port: busy  out  1 (state FILL or RUN); done  out  1 (state DONE); fetch_cnt  out  ADDR_W+1  accepted-instruction count.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, RUN, DONE; internal pc is ADDR_W+1 bits; mem_addr = pc[ADDR_W-1:0] combinationally.
REQ-015 IDLE: start=1 -> FILL; pc unchanged (0 after reset, retained after halt).
REQ-016 FILL: inst<=mem_code, inst_pc<=pc, pc<=pc+1, inst_valid<=1, -> RUN (start-to-valid latency 2 cycles).
REQ-017 RUN: inst_valid=1 held with inst/inst_pc stable until inst_valid&inst_ready.
REQ-018 RUN accept with pc<PROG_LEN: load next word as in FILL same edge; one instruction per cycle at full throughput.
REQ-019 RUN accept with pc==PROG_LEN: inst_valid<=0, -> DONE.
REQ-020 fetch_cnt SHALL increment on every accept, saturate at all-ones, and clear on start from DONE.
REQ-021 DONE: start=1 -> pc<=0 -> FILL; otherwise hold.
REQ-022 halt_req=1 in FILL/RUN: inst_valid<=0, -> IDLE next edge; a same-cycle accept still counts and advances pc; a held unaccepted word is discarded and pc<=inst_pc for refetch.
REQ-023 Priority when simultaneous: rst_n > halt_req > br_valid > accept.
REQ-024 Branch (see REQ-029) in RUN: pc<=br_target, inst_valid<=0, -> FILL; bubble exactly 1 cycle; a same-cycle accept counts; held word is discarded.
REQ-025 br_target >= PROG_LEN SHALL still be fetched; that word is delivered, then -> DONE on its accept.
REQ-026 busy and done SHALL be decoded from state only (no combinational input paths).

Reset
REQ-027 rst_n=0 at a rising edge SHALL, from any state including mid-handshake: state=IDLE, pc=0, inst=0, inst_pc=0, inst_valid=0, fetch_cnt=0.
REQ-028 Outputs after reset: busy=0, done=0, mem_addr=0.

Configuration
REQ-029 Macro IFETCH_BRANCH_EN defined: br_valid/br_target SHALL act per REQ-024; undefined: both ports SHALL remain present but be ignored, and no redirect logic synthesised.

Structure
REQ-030 A shared package SHALL hold the FSM state enum typedef, the ADDR_W default, and the 2-bit instruction-class constants (R=00, I=01, LS=10).
REQ-031 The design SHALL be a single module; the pc/state core shall not be split into a sub-module.

Verification
REQ-032 Reset, start, inst_ready=1 held, PROG_LEN=8 -> inst_valid at cycle 2, inst_pc 0..7 on consecutive cycles, done=1, fetch_cnt=8.
REQ-033 inst_ready toggled 1/0 -> inst stable while not ready, no word skipped or duplicated, fetch_cnt counts accepts only.
REQ-034 Branch to 5 while inst_pc=2 held unaccepted (IFETCH_BRANCH_EN) -> one bubble, next inst_pc=5, word 2 never accepted; without the macro -> stream continues 2,3,4.
REQ-035 halt_req at inst_pc=3 unaccepted, then start -> IDLE, resume with inst_pc=3, fetch_cnt continues from 3.
REQ-036 rst_n low for one edge during RUN at inst_pc=4 -> next cycle IDLE, inst_valid=0, pc=0, fetch_cnt=0.
REQ-037 halt_req and br_valid in the same cycle -> halt wins, IDLE, resume fetches from held inst_pc, not br_target.
